spdif_encode: RTL and testbench



---
 rtl/spdif_encode.sv | 221 ++++++++++++++++++++++
 tb/tb_spdif_encode.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spdif_encode.sv
// spdif_encode: biphase-mark S/PDIF (IEC 60958 consumer) transmitter.
//
// Takes 24-bit stereo samples through a one-deep holding register and
// serialises them as 192-frame blocks of two 32-slot subframes (B/M/W
// preamble, 24 audio bits LSB first, V, U, C, P). It advances one half-cell
// per strobe pulse (128 x fs) supplied by an external divider.
//
// Optional feature: define SPDIF_ENCODE_CHSTAT_EN to send a consumer
// channel-status word on the C bit. When it is undefined, C is 0 in every
// frame and FS_CODE / COPY_PERMIT have no effect.
//
// Ports:
//   clk           system clock (clk_384 domain)
//   reset         synchronous, active-high
//   strobe        one-clk pulse per half-cell, at most one every 2 clk
//   sample_left   left sample, two's complement
//   sample_right  right sample, two's complement
//   sample_valid  one-clk write pulse into the holding register
//   sample_ready  one-clk pulse when the held sample moves to the shifter
//   underrun      one-clk pulse when a frame starts with nothing held
//   block_start   one-clk pulse with the first half-cell of each B preamble
//   spdif         registered biphase-mark line output
//
// Subframe state:
//   SUB_LEFT  | emitting the left subframe (B or M preamble)
//   SUB_RIGHT | emitting the right subframe (W preamble)

module spdif_encode #(
    parameter logic [3:0] FS_CODE           = 4'b0010,
    parameter logic       COPY_PERMIT       = 1'b1,
    parameter logic       VALID_ON_UNDERRUN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        strobe,
    input  logic [23:0] sample_left,
    input  logic [23:0] sample_right,
    input  logic        sample_valid,
    output logic        sample_ready,
    output logic        underrun,
    output logic        block_start,
    output logic        spdif
);

    typedef enum logic {
        SUB_LEFT  = 1'b0,
        SUB_RIGHT = 1'b1
    } sub_t;

    // Preambles as sent after a low line level; first half-cell is the MSB.
    localparam logic [7:0] PRE_B      = 8'b11101000;
    localparam logic [7:0] PRE_M      = 8'b11100010;
    localparam logic [7:0] PRE_W      = 8'b11100100;
    localparam logic [7:0] LAST_FRAME = 8'd191;

    logic [5:0]  hc, hc_n;
    sub_t        sub, sub_n;
    logic [7:0]  frame, frame_n;
    logic        pending, pending_n;
    logic [23:0] hold_l, hold_l_n;
    logic [23:0] hold_r, hold_r_n;
    logic [47:0] shreg, shreg_n;
    logic        v_frame, v_frame_n;
    logic        parity, parity_n;
    logic        pre_inv, pre_inv_n;
    logic        spdif_n;
    logic        sample_ready_n, underrun_n, block_start_n;

    logic [4:0]  slot;
    logic [7:0]  pre_pat;
    logic        c_bit;
    logic        data_bit;
    logic        inv;
    logic        level;

    function automatic logic chstat_bit(input logic [7:0] n);
        logic b;
        b = 1'b0;
        if (n == 8'd2)
            b = COPY_PERMIT;
        else if (n >= 8'd24 && n <= 8'd27)
            b = FS_CODE[n[1:0]];
        return b;
    endfunction

`ifdef SPDIF_ENCODE_CHSTAT_EN
    assign c_bit = chstat_bit(frame);
`else
    assign c_bit = 1'b0;
`endif

    // Line level for the half-cell about to be emitted.
    always_comb begin
        slot    = hc[5:1];
        pre_pat = PRE_M;
        if (sub == SUB_RIGHT)
            pre_pat = PRE_W;
        else if (frame == 8'd0)
            pre_pat = PRE_B;

        case (slot)
            5'd28:   data_bit = v_frame;
            5'd29:   data_bit = 1'b0;
            5'd30:   data_bit = c_bit;
            5'd31:   data_bit = parity;
            default: data_bit = shreg[0];
        endcase

        // Preamble polarity is fixed by the level before its first half-cell
        // and held for all eight half-cells.
        inv = (hc == 6'd0) ? spdif : pre_inv;

        if (hc < 6'd8)
            level = pre_pat[~hc[2:0]] ^ inv;
        else if (!hc[0])
            level = ~spdif;
        else
            level = spdif ^ data_bit;
    end

    always_comb begin
        hc_n           = hc;
        sub_n          = sub;
        frame_n        = frame;
        pending_n      = pending;
        hold_l_n       = hold_l;
        hold_r_n       = hold_r;
        shreg_n        = shreg;
        v_frame_n      = v_frame;
        parity_n       = parity;
        pre_inv_n      = pre_inv;
        spdif_n        = spdif;
        sample_ready_n = 1'b0;
        underrun_n     = 1'b0;
        block_start_n  = 1'b0;

        if (strobe) begin
            spdif_n = level;

            if (hc == 6'd0) begin
                pre_inv_n = spdif;
                parity_n  = 1'b0;
                if (sub == SUB_LEFT) begin
                    block_start_n = (frame == 8'd0);
                    if (pending) begin
                        shreg_n        = {hold_r, hold_l};
                        v_frame_n      = 1'b0;
                        pending_n      = 1'b0;
                        sample_ready_n = 1'b1;
                    end else begin
                        shreg_n    = '0;
                        v_frame_n  = VALID_ON_UNDERRUN;
                        underrun_n = 1'b1;
                    end
                end
            end

            // Bits are committed on the second half-cell of each data slot;
            // parity covers slots 4..30 so P makes the total even.
            if (hc[0] && slot >= 5'd4 && slot <= 5'd30)
                parity_n = parity ^ data_bit;
            // Left audio shifts out first, which brings right into [23:0].
            if (hc[0] && slot >= 5'd4 && slot <= 5'd27)
                shreg_n = {1'b0, shreg[47:1]};

            if (hc == 6'd63) begin
                hc_n = 6'd0;
                if (sub == SUB_RIGHT) begin
                    sub_n   = SUB_LEFT;
                    frame_n = (frame == LAST_FRAME) ? 8'd0 : frame + 8'd1;
                end else begin
                    sub_n = SUB_RIGHT;
                end
            end else begin
                hc_n = hc + 6'd1;
            end
        end

        // A write in the load cycle becomes pending after the old data moved.
        if (sample_valid) begin
            hold_l_n  = sample_left;
            hold_r_n  = sample_right;
            pending_n = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hc           <= 6'd0;
            sub          <= SUB_LEFT;
            frame        <= 8'd0;
            pending      <= 1'b0;
            hold_l       <= '0;
            hold_r       <= '0;
            shreg        <= '0;
            v_frame      <= 1'b0;
            parity       <= 1'b0;
            pre_inv      <= 1'b0;
            spdif        <= 1'b0;
            sample_ready <= 1'b0;
            underrun     <= 1'b0;
            block_start  <= 1'b0;
        end else begin
            hc           <= hc_n;
            sub          <= sub_n;
            frame        <= frame_n;
            pending      <= pending_n;
            hold_l       <= hold_l_n;
            hold_r       <= hold_r_n;
            shreg        <= shreg_n;
            v_frame      <= v_frame_n;
            parity       <= parity_n;
            pre_inv      <= pre_inv_n;
            spdif        <= spdif_n;
            sample_ready <= sample_ready_n;
            underrun     <= underrun_n;
            block_start  <= block_start_n;
        end
    end

endmodule

// File: tb/tb_spdif_encode.sv
// Bench for spdif_encode: a model of the holding register and frame counters
// pushes the expected payload of every frame into a queue at frame load; a
// line monitor decodes each captured subframe and compares it against the
// queue head.

module tb_spdif_encode;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        strobe = 1'b0;
    logic        sample_valid = 1'b0;
    logic [23:0] sample_left = '0;
    logic [23:0] sample_right = '0;
    logic        sample_ready, underrun, block_start, spdif;

    spdif_encode dut (
        .clk          (clk),
        .reset        (reset),
        .strobe       (strobe),
        .sample_left  (sample_left),
        .sample_right (sample_right),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .underrun     (underrun),
        .block_start  (block_start),
        .spdif        (spdif)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic exp_c(input int f);
`ifdef SPDIF_ENCODE_CHSTAT_EN
        return (f == 2) || (f == 25);
`else
        return (f < 0);
`endif
    endfunction

    typedef struct {
        logic [23:0] l;
        logic [23:0] r;
        logic        v;
        logic        c;
    } frame_rec_t;

    frame_rec_t sb_q[$];

    // Strobe: one pulse every 2 clk while enabled.
    bit strobe_en = 1'b0;
    initial forever begin
        @(negedge clk);
        strobe = strobe_en ? ~strobe : 1'b0;
    end

    // Model / monitor state
    int          m_hc = 0, m_frame = 0;
    bit          m_sub = 1'b0, m_pend = 1'b0;
    logic [23:0] m_hl = '0, m_hr = '0;
    logic        m_level = 1'b0;
    int          c_hc = 0, c_frame = 0;
    bit          c_sub = 1'b0;
    bit          s_rst, s_stb, e_bs, e_rdy, e_unr;
    logic [63:0] sf = '0;
    logic        sf_lvl0 = 1'b0;
    frame_rec_t  rec;

    int          frames_done = 0;
    int          cnt_rdy = 0, cnt_unr = 0, cnt_bs = 0;
    logic [23:0] dec_l = '0, dec_r = '0;
    logic        dec_vl = 1'b0, dec_pl = 1'b0, dec_pr = 1'b0, dec_cl = 1'b0, dec_cr = 1'b0;
    logic [7:0]  first_b = '0;

    task automatic decode_sub();
        logic [7:0]  pre, exp_pre;
        logic [27:0] bits;
        int          viol;
        logic        lvl, a, b;
        for (int i = 0; i < 8; i++) pre[7-i] = sf[i];
        if (c_sub)             exp_pre = 8'b11100100;
        else if (c_frame == 0) exp_pre = 8'b11101000;
        else                   exp_pre = 8'b11100010;
        if (sf_lvl0) exp_pre = ~exp_pre;
        check("preamble", {24'd0, pre}, {24'd0, exp_pre});
        if (!c_sub && c_frame == 0) first_b = pre;
        viol = 0;
        lvl  = sf[7];
        for (int s = 4; s < 32; s++) begin
            a = sf[2*s];
            b = sf[2*s+1];
            if (a === lvl) viol++;
            bits[s-4] = a ^ b;
            lvl = b;
        end
        check("bmc_violations", viol, 0);
        check("parity_even", {31'd0, ^bits}, 0);
        check("end_level", {31'd0, sf[63]}, {31'd0, sf_lvl0});
        check("scoreboard_size", sb_q.size(), 1);
        if (sb_q.size() > 0) begin
            rec = sb_q[0];
            if (c_sub) check("audio_right", {8'd0, bits[23:0]}, {8'd0, rec.r});
            else       check("audio_left",  {8'd0, bits[23:0]}, {8'd0, rec.l});
            check("v_bit", {31'd0, bits[24]}, {31'd0, rec.v});
            check("u_bit", {31'd0, bits[25]}, 0);
            check("c_bit", {31'd0, bits[26]}, {31'd0, rec.c});
        end
        if (c_sub) begin
            dec_r  = bits[23:0];
            dec_pr = bits[27];
            dec_cr = bits[26];
            if (sb_q.size() > 0) void'(sb_q.pop_front());
            frames_done++;
        end else begin
            dec_l  = bits[23:0];
            dec_vl = bits[24];
            dec_pl = bits[27];
            dec_cl = bits[26];
        end
    endtask

    always @(posedge clk) begin
        e_bs  = 1'b0;
        e_rdy = 1'b0;
        e_unr = 1'b0;
        s_rst = reset;
        s_stb = strobe;
        if (reset) begin
            m_hc = 0; m_sub = 1'b0; m_frame = 0; m_pend = 1'b0;
            sb_q.delete();
        end else begin
            if (strobe) begin
                c_hc = m_hc; c_sub = m_sub; c_frame = m_frame;
                if (m_hc == 0 && !m_sub) begin
                    rec.l = m_pend ? m_hl : 24'd0;
                    rec.r = m_pend ? m_hr : 24'd0;
                    rec.v = !m_pend;
                    rec.c = exp_c(m_frame);
                    sb_q.push_back(rec);
                    e_rdy  = m_pend;
                    e_unr  = !m_pend;
                    e_bs   = (m_frame == 0);
                    m_pend = 1'b0;
                end
                if (m_hc == 63) begin
                    m_hc = 0;
                    if (m_sub) m_frame = (m_frame == 191) ? 0 : m_frame + 1;
                    m_sub = !m_sub;
                end else begin
                    m_hc++;
                end
            end
            if (sample_valid) begin
                m_hl = sample_left; m_hr = sample_right; m_pend = 1'b1;
            end
        end
        #1;
        check("block_start", {31'd0, block_start}, {31'd0, e_bs});
        check("sample_ready", {31'd0, sample_ready}, {31'd0, e_rdy});
        check("underrun", {31'd0, underrun}, {31'd0, e_unr});
        if (sample_ready) cnt_rdy++;
        if (underrun)     cnt_unr++;
        if (block_start)  cnt_bs++;
        if (s_rst) begin
            m_level = 1'b0;
            check("spdif_reset", {31'd0, spdif}, 0);
        end else if (s_stb) begin
            if (c_hc == 0) sf_lvl0 = m_level;
            sf[c_hc] = spdif;
            m_level  = spdif;
            if (c_hc == 63) decode_sub();
        end else begin
            check("spdif_hold", {31'd0, spdif}, {31'd0, m_level});
        end
    end

    task automatic reset_dut();
        strobe_en = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic write_sample(input logic [23:0] l, input logic [23:0] r);
        @(negedge clk);
        sample_left  = l;
        sample_right = r;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic wait_frames(input int n);
        int target, cyc;
        target = frames_done + n;
        cyc    = 0;
        while (frames_done < target && cyc < n * 300 + 400) begin
            @(negedge clk);
            cyc++;
        end
        if (frames_done < target) check("wait_frames_timeout", frames_done, target);
    endtask

    task automatic wait_ready();
        int cyc;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!sample_ready && cyc < 600);
        if (!sample_ready) check("wait_ready_timeout", {31'd0, sample_ready}, 1);
    endtask

    typedef struct {
        logic [23:0] l;
        logic [23:0] r;
        logic        pl;
        logic        pr;
    } vec_t;

    vec_t tbl[7];
    int   s_rdy, s_unr, s_bs, f0, cyc;

    initial begin
        // Payload and hand-counted audio parity (V=U=0 in loaded frames).
        tbl[0] = '{24'h000000, 24'hFFFFFF, 1'b0, 1'b0};
        tbl[1] = '{24'h123456, 24'hAAAAAA, 1'b1, 1'b0};
        tbl[2] = '{24'h7FFFFF, 24'h000001, 1'b1, 1'b1};
        tbl[3] = '{24'h800000, 24'h555555, 1'b1, 1'b0};
        tbl[4] = '{24'hFFFFFE, 24'h000003, 1'b1, 1'b0};
        tbl[5] = '{24'h0F0F0F, 24'h100000, 1'b0, 1'b1};
        tbl[6] = '{24'hC00001, 24'hFFFFFF, 1'b1, 1'b0};

        // Reset state
        reset_dut();
        check("rst_spdif", {31'd0, spdif}, 0);
        check("rst_sample_ready", {31'd0, sample_ready}, 0);
        check("rst_underrun", {31'd0, underrun}, 0);
        check("rst_block_start", {31'd0, block_start}, 0);

        // No samples: underrun frame
        s_unr = cnt_unr; s_rdy = cnt_rdy;
        strobe_en = 1'b1;
        wait_frames(1);
        check("t1_underrun_pulses", cnt_unr - s_unr, 1);
        check("t1_ready_pulses", cnt_rdy - s_rdy, 0);
        check("t1_first_preamble", {24'd0, first_b}, 32'h000000E8);
        check("t1_v_bit", {31'd0, dec_vl}, 1);
        check("t1_left_audio", {8'd0, dec_l}, 0);

        // Single-bit samples at both ends of the word
        reset_dut();
        write_sample(24'h000001, 24'h800000);
        s_rdy = cnt_rdy;
        strobe_en = 1'b1;
        wait_frames(1);
        check("t2_ready_pulses", cnt_rdy - s_rdy, 1);
        check("t2_left", {8'd0, dec_l}, 32'h000001);
        check("t2_right", {8'd0, dec_r}, 32'h800000);
        check("t2_v_bit", {31'd0, dec_vl}, 0);
        check("t2_p_left", {31'd0, dec_pl}, 1);
        check("t2_p_right", {31'd0, dec_pr}, 1);

        // Two writes in one frame period: latest wins
        reset_dut();
        strobe_en = 1'b1;
        repeat (20) @(negedge clk);
        write_sample(24'hAAAA01, 24'h0000AA);
        write_sample(24'h5555B2, 24'h00BB00);
        s_rdy = cnt_rdy;
        wait_frames(2);
        check("t3_ready_pulses", cnt_rdy - s_rdy, 1);
        check("t3_left", {8'd0, dec_l}, 32'h5555B2);
        check("t3_right", {8'd0, dec_r}, 32'h00BB00);

        // Table-driven payloads
        reset_dut();
        write_sample(tbl[0].l, tbl[0].r);
        strobe_en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            wait_ready();
            if (i < 6) write_sample(tbl[i+1].l, tbl[i+1].r);
            wait_frames(1);
            check("tbl_left", {8'd0, dec_l}, {8'd0, tbl[i].l});
            check("tbl_right", {8'd0, dec_r}, {8'd0, tbl[i].r});
            check("tbl_parity_left", {31'd0, dec_pl ^ dec_cl}, {31'd0, tbl[i].pl});
            check("tbl_parity_right", {31'd0, dec_pr ^ dec_cr}, {31'd0, tbl[i].pr});
            check("tbl_v_bit", {31'd0, dec_vl}, 0);
        end

        // Full block of constant data
        reset_dut();
        write_sample(24'h3C3C3C, 24'hC3C3C3);
        s_bs = cnt_bs; f0 = frames_done;
        strobe_en = 1'b1;
        for (int f = 0; f < 193; f++) begin
            wait_ready();
            if (f < 192) write_sample(24'h3C3C3C, 24'hC3C3C3);
        end
        check("t4_block_start_pulses", cnt_bs - s_bs, 2);
        check("t4_frames", frames_done - f0, 192);

        // Reset at half-cell 30 of a right subframe, with a sample pending
        write_sample(24'h00FF00, 24'h0F0F0F);
        cyc = 0;
        while (!(m_sub && m_hc == 30) && cyc < 600) begin
            @(negedge clk);
            cyc++;
        end
        check("t5_reach_hc30", {31'd0, m_sub}, 1);
        reset = 1'b1;
        @(negedge clk);
        check("t5_spdif_after_reset", {31'd0, spdif}, 0);
        reset = 1'b0;
        s_unr = cnt_unr; s_rdy = cnt_rdy; s_bs = cnt_bs;
        wait_frames(1);
        check("t5_underrun_pulses", cnt_unr - s_unr, 1);
        check("t5_ready_pulses", cnt_rdy - s_rdy, 0);
        check("t5_block_start", cnt_bs - s_bs, 1);
        check("t5_first_preamble", {24'd0, first_b}, 32'h000000E8);
        check("t5_v_bit", {31'd0, dec_vl}, 1);

        strobe_en = 1'b0;
        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", n_tests, n_fail + 1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

endmodule
